// File: rtl/reg_bank_mp.sv
// rtl/reg_bank_mp.sv - multi-read-port register file with zero register, bypass, dirty tracking and clear sweep
//
// Purpose
//   Register file for the MIPS datapath. It has NUM_RD combinational read ports and one
//   synchronous write port. Entry 0 can optionally be hardwired to zero. The write can
//   optionally be forwarded to the read ports in the same cycle. Each entry has a dirty bit.
//   A sequential clear engine zeroes the whole file one entry per cycle, without a reset.
//
// Ports
//   clk       clock; all state updates happen on the rising edge
//   rst       synchronous, active-low reset
//   rd_addr   read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
//   rd_data   read data, combinational; port p uses bits [p*DATA_W +: DATA_W]
//   wr_en     write strobe
//   wr_addr   write address
//   wr_data   write data
//   clr_req   clear request; honoured only when the engine is idle
//   clr_busy  high while the clear sweep runs
//   clr_done  one-cycle pulse on the cycle after the last entry is swept
//   wr_drop   one-cycle pulse when a write is discarded because the engine is not idle
//   dirty     bit k set: entry k has been written since the last reset or clear

module reg_bank_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     wr_drop,
    output logic [DEPTH-1:0]         dirty
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The counter is one bit wider than an address so that the compare against the
    // last entry can never wrap around.
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    state_t              state;
    logic [ADDR_W:0]     cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    dirty_q;

    logic                wr_to_zero;
    logic                wr_accept;
    logic                wr_effective;

    // A write to entry 0 with ZERO_REG set is still accepted, so it never raises wr_drop.
    // It does nothing, though: no storage update, no dirty bit, and no forwarding.
    assign wr_to_zero   = ZERO_REG && (wr_addr == '0);
    assign wr_accept    = rst && wr_en && (state == ST_IDLE);
    assign wr_effective = wr_accept && !wr_to_zero;

    assign clr_busy = (state == ST_CLEAR);
    assign clr_done = (state == ST_DONE);
    assign wr_drop  = rst && wr_en && (state != ST_IDLE);
    assign dirty    = dirty_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            dirty_q <= '0;
            state   <= ST_IDLE;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A write in the same cycle as clr_req still lands.
                    // The sweep zeroes it later.
                    if (wr_effective) begin
                        mem[wr_addr]     <= wr_data;
                        dirty_q[wr_addr] <= 1'b1;
                    end
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    mem[cnt[ADDR_W-1:0]]     <= '0;
                    dirty_q[cnt[ADDR_W-1:0]] <= 1'b0;
                    cnt                      <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read ports. The zero register wins over everything else.
    // Next comes forwarding of this cycle's write, and last the stored value.
    // Entries already swept read 0 straight from storage, because the sweep writes them.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;

        assign ra = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            val = mem[ra];
            if (ZERO_REG && (ra == '0)) begin
                val = '0;
            end else if (BYPASS && wr_effective && (wr_addr == ra)) begin
                val = wr_data;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = val;
    end

endmodule
